// File: rtl/axi4lite_pkg.sv
// axi4lite_pkg: AXI4-Lite response codes and memory-bridge state encoding
package axi4lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        WR_REQ,
        WR_RESP,
        RESP
    } bridge_state_t;

    function automatic logic resp_is_err(input logic [1:0] r);
        return r == RESP_SLVERR || r == RESP_DECERR;
    endfunction

endpackage

// File: rtl/axi4lite_mem_bridge.sv
// axi4lite_mem_bridge: single-outstanding core memory request to AXI4-Lite master bridge
module axi4lite_mem_bridge
    import axi4lite_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        master_awvalid,
    output logic [31:0] master_awaddr,
    input  logic        master_awready,
    output logic        master_wvalid,
    output logic [31:0] master_wdata,
    output logic [3:0]  master_wstrb,
    input  logic        master_wready,
    output logic        master_bready,
    input  logic        master_bvalid,
    input  logic [1:0]  master_bresp,
    output logic        master_arvalid,
    output logic [31:0] master_araddr,
    input  logic        master_arready,
    output logic        master_rready,
    input  logic        master_rvalid,
    input  logic [1:0]  master_rresp,
    input  logic [31:0] master_rdata
);

    bridge_state_t state, state_nxt;
    logic [31:0]   addr_q, wdata_q, rdata_q;
    logic [3:0]    wstrb_q;
    logic          aw_done, w_done, err_q;
    logic          accept, aw_all, w_all;

    assign req_ready      = state == IDLE && !rst;
    assign accept         = req_valid && req_ready;
    assign master_arvalid = state == RD_ADDR;
    assign master_araddr  = addr_q;
    assign master_rready  = state == RD_DATA;
    assign master_awvalid = state == WR_REQ && !aw_done;
    assign master_awaddr  = addr_q;
    assign master_wvalid  = state == WR_REQ && !w_done;
    assign master_wdata   = wdata_q;
    assign master_wstrb   = wstrb_q;
    assign master_bready  = state == WR_RESP;
    assign resp_valid     = state == RESP;
    assign resp_rdata     = rdata_q;
    assign resp_err       = err_q;
    // a channel counts as complete either from an earlier handshake or one happening now
    assign aw_all = aw_done || (master_awvalid && master_awready);
    assign w_all  = w_done || (master_wvalid && master_wready);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = req_we ? WR_REQ : RD_ADDR;
            RD_ADDR: if (master_arready) state_nxt = RD_DATA;
            RD_DATA: if (master_rvalid) state_nxt = RESP;
            WR_REQ:  if (aw_all && w_all) state_nxt = WR_RESP;
            WR_RESP: if (master_bvalid) state_nxt = RESP;
            RESP:    if (resp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_nxt;
            aw_done <= state == WR_REQ && aw_all && !w_all;
            w_done  <= state == WR_REQ && w_all && !aw_all;
            if (state == RD_DATA && master_rvalid) begin
                rdata_q <= master_rdata;
                err_q   <= resp_is_err(master_rresp);
            end else if (state == WR_RESP && master_bvalid) begin
                rdata_q <= '0;
                err_q   <= resp_is_err(master_bresp);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            wstrb_q <= req_wstrb;
        end
    end

endmodule

// File: tb/tb_axi4lite_mem_bridge.sv
// tb_axi4lite_mem_bridge: directed checks of the bridge against a small configurable AXI4-Lite slave
module tb_axi4lite_mem_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_wstrb;
    logic        resp_valid, resp_ready, resp_err;
    logic [31:0] resp_rdata;
    logic        master_awvalid, master_awready;
    logic [31:0] master_awaddr;
    logic        master_wvalid, master_wready;
    logic [31:0] master_wdata;
    logic [3:0]  master_wstrb;
    logic        master_bready, master_bvalid;
    logic [1:0]  master_bresp;
    logic        master_arvalid, master_arready;
    logic [31:0] master_araddr;
    logic        master_rready, master_rvalid;
    logic [1:0]  master_rresp;
    logic [31:0] master_rdata;

    int          aw_delay, w_delay, ar_delay;
    logic [1:0]  rresp_cfg, bresp_cfg;
    logic [31:0] rdata_cfg;
    int          aw_cnt, w_cnt, ar_cnt;
    logic        aw_got, w_got;
    int          aw_vcyc = 0, w_vcyc = 0, b_hs = 0;
    int          n_pass = 0, n_total = 0;
    int          lat, ar_cyc, rr_cyc;
    logic [31:0] seen_addr, seen_wdata;
    logic [3:0]  seen_wstrb;

    always #5 clk = ~clk;

    axi4lite_mem_bridge dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .master_awvalid(master_awvalid), .master_awaddr(master_awaddr), .master_awready(master_awready),
        .master_wvalid(master_wvalid), .master_wdata(master_wdata), .master_wstrb(master_wstrb),
        .master_wready(master_wready),
        .master_bready(master_bready), .master_bvalid(master_bvalid), .master_bresp(master_bresp),
        .master_arvalid(master_arvalid), .master_araddr(master_araddr), .master_arready(master_arready),
        .master_rready(master_rready), .master_rvalid(master_rvalid), .master_rresp(master_rresp),
        .master_rdata(master_rdata)
    );

    // slave: each ready rises once its valid has waited the configured number of cycles
    assign master_awready = master_awvalid && aw_cnt >= aw_delay;
    assign master_wready  = master_wvalid && w_cnt >= w_delay;
    assign master_arready = master_arvalid && ar_cnt >= ar_delay;
    assign master_rresp   = rresp_cfg;
    assign master_bresp   = bresp_cfg;
    assign master_rdata   = rdata_cfg;

    always @(posedge clk) begin
        if (rst) begin
            aw_cnt <= 0;
            w_cnt <= 0;
            ar_cnt <= 0;
            aw_got <= 1'b0;
            w_got <= 1'b0;
            master_rvalid <= 1'b0;
            master_bvalid <= 1'b0;
        end else begin
            aw_cnt <= (master_awvalid && !master_awready) ? aw_cnt + 1 : 0;
            w_cnt <= (master_wvalid && !master_wready) ? w_cnt + 1 : 0;
            ar_cnt <= (master_arvalid && !master_arready) ? ar_cnt + 1 : 0;
            if (master_rvalid && master_rready) master_rvalid <= 1'b0;
            if (master_arvalid && master_arready) master_rvalid <= 1'b1;
            if (master_bvalid && master_bready) master_bvalid <= 1'b0;
            if ((aw_got || (master_awvalid && master_awready)) && (w_got || (master_wvalid && master_wready))) begin
                master_bvalid <= 1'b1;
                aw_got <= 1'b0;
                w_got <= 1'b0;
            end else begin
                if (master_awvalid && master_awready) aw_got <= 1'b1;
                if (master_wvalid && master_wready) w_got <= 1'b1;
            end
        end
    end

    always @(posedge clk) begin
        aw_vcyc <= aw_vcyc + int'(master_awvalid);
        w_vcyc <= w_vcyc + int'(master_wvalid);
        b_hs <= b_hs + int'(master_bvalid && master_bready);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // issue one request from IDLE at a negedge, return at the negedge where resp_valid is first seen
    task automatic txn(input logic we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        req_valid = 1'b1;
        req_we = we;
        req_addr = a;
        req_wdata = d;
        req_wstrb = s;
        check("accept_ready", 32'(req_ready), 1);
        lat = 0;
        ar_cyc = -1;
        rr_cyc = -1;
        do begin
            @(negedge clk);
            lat++;
            req_valid = 1'b0;
            if (master_arvalid) begin
                if (ar_cyc < 0) ar_cyc = lat;
                seen_addr = master_araddr;
            end
            if (master_awvalid) seen_addr = master_awaddr;
            if (master_wvalid) begin
                seen_wdata = master_wdata;
                seen_wstrb = master_wstrb;
            end
            if (master_rready && rr_cyc < 0) rr_cyc = lat;
        end while (!resp_valid && lat < 40);
        check("resp_arrived", 32'(resp_valid), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int a0, w0, b0, n;
        rst = 1'b1;
        req_valid = 1'b0;
        req_we = 1'b0;
        req_addr = '0;
        req_wdata = '0;
        req_wstrb = '0;
        resp_ready = 1'b1;
        aw_delay = 0;
        w_delay = 0;
        ar_delay = 0;
        rresp_cfg = 2'b00;
        bresp_cfg = 2'b00;
        rdata_cfg = '0;
        repeat (2) @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 0);
        check("rst_resp_valid", 32'(resp_valid), 0);
        check("rst_rdata", resp_rdata, 0);
        check("rst_err", 32'(resp_err), 0);
        check("rst_valids", 32'({master_arvalid, master_awvalid, master_wvalid, master_bready, master_rready}), 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_req_ready", 32'(req_ready), 1);

        rdata_cfg = 32'hDEAD_BEEF;
        txn(1'b0, 32'h8000_0010, 32'h0, 4'h0);
        check("rd_latency", lat, 3);
        check("rd_arvalid_cycle", ar_cyc, 1);
        check("rd_rready_cycle", rr_cyc, 2);
        check("rd_araddr", seen_addr, 32'h8000_0010);
        check("rd_rdata", resp_rdata, 32'hDEAD_BEEF);
        check("rd_err", 32'(resp_err), 0);
        @(negedge clk);

        aw_delay = 3;
        a0 = aw_vcyc;
        w0 = w_vcyc;
        b0 = b_hs;
        txn(1'b1, 32'h8000_0020, 32'h1234_5678, 4'b0011);
        check("wr_latency", lat, 6);
        check("wr_awvalid_cycles", aw_vcyc - a0, 4);
        check("wr_wvalid_cycles", w_vcyc - w0, 1);
        check("wr_b_count", b_hs - b0, 1);
        check("wr_awaddr", seen_addr, 32'h8000_0020);
        check("wr_wdata", seen_wdata, 32'h1234_5678);
        check("wr_wstrb", 32'(seen_wstrb), 32'h3);
        check("wr_rdata", resp_rdata, 0);
        check("wr_err", 32'(resp_err), 0);
        aw_delay = 0;
        @(negedge clk);

        rdata_cfg = 32'h0BAD_F00D;
        rresp_cfg = 2'b11;
        txn(1'b0, 32'h8000_0030, 32'h0, 4'h0);
        check("rd_decerr_err", 32'(resp_err), 1);
        check("rd_decerr_rdata", resp_rdata, 32'h0BAD_F00D);
        @(negedge clk);
        bresp_cfg = 2'b10;
        txn(1'b1, 32'h8000_0034, 32'hFFFF_FFFF, 4'hF);
        check("wr_slverr_err", 32'(resp_err), 1);
        check("wr_slverr_rdata", resp_rdata, 0);
        @(negedge clk);
        rdata_cfg = 32'h00C0_FFEE;
        rresp_cfg = 2'b01;
        txn(1'b0, 32'h8000_0038, 32'h0, 4'h0);
        check("rd_exokay_err", 32'(resp_err), 0);
        check("rd_exokay_rdata", resp_rdata, 32'h00C0_FFEE);
        @(negedge clk);
        bresp_cfg = 2'b01;
        txn(1'b1, 32'h8000_003C, 32'h1, 4'h1);
        check("wr_exokay_err", 32'(resp_err), 0);
        @(negedge clk);
        rresp_cfg = 2'b00;
        bresp_cfg = 2'b00;

        resp_ready = 1'b0;
        rdata_cfg = 32'h55AA_1234;
        txn(1'b0, 32'h8000_0044, 32'h0, 4'h0);
        rdata_cfg = 32'h0;
        for (int i = 0; i < 5; i++) begin
            check("stall_resp_valid", 32'(resp_valid), 1);
            check("stall_rdata", resp_rdata, 32'h55AA_1234);
            check("stall_req_ready", 32'(req_ready), 0);
            @(negedge clk);
        end
        resp_ready = 1'b1;
        check("consume_req_ready", 32'(req_ready), 0);
        @(negedge clk);
        check("after_consume_req_ready", 32'(req_ready), 1);
        check("after_consume_resp_valid", 32'(resp_valid), 0);

        rdata_cfg = 32'h1111_2222;
        req_valid = 1'b1;
        req_we = 1'b0;
        req_addr = 32'h8000_0040;
        @(negedge clk);
        req_valid = 1'b0;
        check("mid_arvalid", 32'(master_arvalid), 1);
        @(negedge clk);
        check("mid_rready", 32'(master_rready), 1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_valids", 32'({master_arvalid, master_awvalid, master_wvalid, master_bready, master_rready}), 0);
        check("mid_rst_resp_valid", 32'(resp_valid), 0);
        check("mid_rst_req_ready", 32'(req_ready), 0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_req_ready", 32'(req_ready), 1);
        check("post_rst_resp_valid", 32'(resp_valid), 0);
        rdata_cfg = 32'h3333_4444;
        txn(1'b0, 32'h8000_0048, 32'h0, 4'h0);
        check("post_rst_latency", lat, 3);
        check("post_rst_rdata", resp_rdata, 32'h3333_4444);
        @(negedge clk);

        rdata_cfg = 32'hA5A5_A5A5;
        req_valid = 1'b1;
        req_we = 1'b0;
        req_addr = 32'h8000_0050;
        @(negedge clk);
        check("b2b_arvalid", 32'(master_arvalid), 1);
        req_we = 1'b1;
        req_addr = 32'h8000_0060;
        req_wdata = 32'hCAFE_F00D;
        req_wstrb = 4'hF;
        @(negedge clk);
        @(negedge clk);
        check("b2b_rd_resp_valid", 32'(resp_valid), 1);
        check("b2b_rd_rdata", resp_rdata, 32'hA5A5_A5A5);
        check("b2b_busy_req_ready", 32'(req_ready), 0);
        @(negedge clk);
        check("b2b_idle_req_ready", 32'(req_ready), 1);
        check("b2b_idle_resp_valid", 32'(resp_valid), 0);
        @(negedge clk);
        req_valid = 1'b0;
        check("b2b_awvalid", 32'(master_awvalid), 1);
        check("b2b_awaddr", master_awaddr, 32'h8000_0060);
        n = 0;
        while (!resp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("b2b_wr_latency", n, 2);
        check("b2b_wr_err", 32'(resp_err), 0);
        check("b2b_wr_rdata", resp_rdata, 0);
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
